// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-to-ALU controller for the BCD calculator.
// Builds operand A, operand B and the operator from one-cycle key events.
// It then presents stable operands to a combinational BCD ALU, waits for
// that ALU's valid flag (with a timeout), and latches the result for display.
// Ports:
//   clk, reset          : clock, async active-high reset
//   keyValid, keyCode   : key event (0-9 digit, 10 '+', 11 '-', 12 '=', 13 clear)
//   num1, num2, op      : ALU operands / operation (0 add, 1 sub)
//   aluValid, aluRes    : ALU result handshake
//   disp, dispNeg       : display value and minus sign (all-E = error)
//   busy, error         : calculating / sticky error
module calc_sequencer #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                keyValid,
  input  logic [3:0]          keyCode,
  output logic [4*DIGITS-1:0] num1,
  output logic [4*DIGITS-1:0] num2,
  output logic                op,
  input  logic                aluValid,
  input  logic [4*DIGITS-1:0] aluRes,
  output logic [4*DIGITS-1:0] disp,
  output logic                dispNeg,
  output logic                busy,
  output logic                error
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [3:0]    TMO_LAST = 4'(TIMEOUT-1);
  localparam logic [W-1:0]  ERR_PAT  = {DIGITS{4'hE}};

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_t;

  state_t         r_state;
  logic [W-1:0]   r_regA, r_regB, r_result, r_num1, r_num2, r_disp;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_timer;
  logic           r_op, r_neg, r_dispNeg, r_busy, r_error;
  logic           r_go;  // '=' accepted; CALC is entered on the following edge

  logic           w_digit, w_opk, w_eq, w_clr, w_sclr;
  logic [W-1:0]   w_shA, w_shB, w_dig;
  logic           w_lt, w_dec;

  assign w_digit = keyValid && (keyCode <= 4'd9);
  assign w_opk   = keyValid && (keyCode == 4'd10 || keyCode == 4'd11);
  assign w_eq    = keyValid && (keyCode == 4'd12);
  assign w_clr   = keyValid && (keyCode == 4'd13);
  // clear is dropped while calculating, including the hand-off cycle
  assign w_sclr  = w_clr && (r_state != CALC) && !r_go;
  assign w_shA   = {r_regA[W-5:0], keyCode};
  assign w_shB   = {r_regB[W-5:0], keyCode};
  assign w_dig   = {{(W-4){1'b0}}, keyCode};

  // BCD magnitude compare, most-significant digit decides first
  always_comb begin
    w_lt  = 1'b0;
    w_dec = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      if (!w_dec) begin
        if (r_regA[4*i +: 4] < r_regB[4*i +: 4]) begin
          w_lt  = 1'b1;
          w_dec = 1'b1;
        end else if (r_regA[4*i +: 4] > r_regB[4*i +: 4]) begin
          w_dec = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ENTER_A;  r_regA <= '0;  r_regB <= '0;  r_cnt <= '0;
      r_op <= 1'b0;  r_neg <= 1'b0;  r_result <= '0;  r_timer <= '0;
      r_num1 <= '0;  r_num2 <= '0;  r_disp <= '0;  r_dispNeg <= 1'b0;
      r_busy <= 1'b0;  r_error <= 1'b0;  r_go <= 1'b0;
    end else if (w_sclr) begin
      r_state <= ENTER_A;  r_regA <= '0;  r_regB <= '0;  r_cnt <= '0;
      r_op <= 1'b0;  r_neg <= 1'b0;  r_result <= '0;  r_timer <= '0;
      r_num1 <= '0;  r_num2 <= '0;  r_disp <= '0;  r_dispNeg <= 1'b0;
      r_busy <= 1'b0;  r_error <= 1'b0;  r_go <= 1'b0;
    end else begin
      case (r_state)
        ENTER_A: begin
          if (w_digit && r_cnt != CNT_FULL) begin
            r_regA <= w_shA;
            r_disp <= w_shA;
            r_cnt  <= r_cnt + CW'(1);
          end else if (w_opk) begin
            r_op    <= keyCode[0];
            r_cnt   <= '0;
            r_regB  <= '0;
            r_disp  <= '0;
            r_state <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (r_go) begin
            r_go    <= 1'b0;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_state <= CALC;
            // subtraction with A<B: compute B-A and show it negative
            if (r_op && w_lt) begin
              r_num1 <= r_regB;  r_num2 <= r_regA;  r_neg <= 1'b1;
            end else begin
              r_num1 <= r_regA;  r_num2 <= r_regB;  r_neg <= 1'b0;
            end
          end else if (w_digit && r_cnt != CNT_FULL) begin
            r_regB <= w_shB;
            r_disp <= w_shB;
            r_cnt  <= r_cnt + CW'(1);
          end else if (w_opk && r_cnt == '0) begin
            r_op <= keyCode[0];
          end else if (w_eq && r_cnt != '0) begin
            r_go <= 1'b1;
          end
        end
        CALC: begin
          // timer==0 marks the first CALC cycle, where aluValid is not trusted
          if (r_timer != '0 && aluValid) begin
            r_result  <= aluRes;
            r_disp    <= aluRes;
            r_dispNeg <= r_neg;
            r_busy    <= 1'b0;
            r_state   <= SHOW;
          end else if (r_timer == TMO_LAST) begin
            r_error   <= 1'b1;
            r_disp    <= ERR_PAT;
            r_dispNeg <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= SHOW;
          end else begin
            r_timer <= r_timer + 4'd1;
          end
        end
        SHOW: begin
          if (w_digit) begin
            r_regA    <= w_dig;
            r_disp    <= w_dig;
            r_cnt     <= CW'(1);
            r_error   <= 1'b0;
            r_dispNeg <= 1'b0;
            r_state   <= ENTER_A;
          end else if (w_opk && !r_error && !r_dispNeg) begin
            // chain: previous result becomes operand A
            r_regA  <= r_result;
            r_op    <= keyCode[0];
            r_regB  <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_state <= ENTER_B;
          end
        end
        default: r_state <= ENTER_A;
      endcase
    end
  end

  assign num1    = r_num1;
  assign num2    = r_num2;
  assign op      = r_op;
  assign disp    = r_disp;
  assign dispNeg = r_dispNeg;
  assign busy    = r_busy;
  assign error   = r_error;
endmodule
